// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// The full result is computed when an op is accepted and held in pending
// registers; Busy then runs for a fixed cycle count before HI/LO commit.
module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDUOP,
  input  logic        Start,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUOut
);

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMfhi  = 4'd5;
  localparam logic [3:0] OpMflo  = 4'd6;
  localparam logic [3:0] OpMthi  = 4'd7;
  localparam logic [3:0] OpMtlo  = 4'd8;

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       pend_hi_q, pend_hi_d;
  logic [31:0]       pend_lo_q, pend_lo_d;
  logic              pend_valid_q, pend_valid_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;

  logic signed [63:0] a_s64, b_s64, prod_s;
  logic        [63:0] prod_u;
  // 33-bit signed divide so that 0x80000000 / -1 yields +2^31 without overflow
  logic signed [32:0] dvd_s, dvs_s, quo_s, rem_s;
  logic        [31:0] dvs_u, quo_u, rem_u;
  logic               start_op;
  logic               div_by_zero;

  // Result arithmetic for all four ops, from the current operands
  always_comb begin
    a_s64       = {{32{SrcA[31]}}, SrcA};
    b_s64       = {{32{SrcB[31]}}, SrcB};
    prod_s      = a_s64 * b_s64;
    prod_u      = {32'd0, SrcA} * {32'd0, SrcB};
    div_by_zero = (SrcB == 32'd0);
    // Substitute a divisor of 1 on zero so no X is produced; result is discarded
    dvd_s       = {SrcA[31], SrcA};
    dvs_s       = div_by_zero ? 33'sd1 : {SrcB[31], SrcB};
    quo_s       = dvd_s / dvs_s;
    rem_s       = dvd_s % dvs_s;
    dvs_u       = div_by_zero ? 32'd1 : SrcB;
    quo_u       = SrcA / dvs_u;
    rem_u       = SrcA % dvs_u;
  end

  assign start_op = Start && (MDUOP >= OpMult) && (MDUOP <= OpDivu);

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      pend_hi_q    <= '0;
      pend_lo_q    <= '0;
      pend_valid_q <= 1'b0;
      hi_q         <= '0;
      lo_q         <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_hi_q    <= pend_hi_d;
      pend_lo_q    <= pend_lo_d;
      pend_valid_q <= pend_valid_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
    end
  end

  // Next-state: accept ops and MT writes when idle, count down and commit when busy
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_hi_d    = pend_hi_q;
    pend_lo_d    = pend_lo_q;
    pend_valid_d = pend_valid_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    case (state_q)
      StIdle: begin
        if (start_op) begin
          state_d      = StBusy;
          pend_valid_d = 1'b1;
          case (MDUOP)
            OpMult: begin
              cnt_d     = CntW'(MULT_CYCLES);
              pend_hi_d = prod_s[63:32];
              pend_lo_d = prod_s[31:0];
            end
            OpMultu: begin
              cnt_d     = CntW'(MULT_CYCLES);
              pend_hi_d = prod_u[63:32];
              pend_lo_d = prod_u[31:0];
            end
            OpDiv: begin
              cnt_d        = CntW'(DIV_CYCLES);
              pend_hi_d    = rem_s[31:0];
              pend_lo_d    = quo_s[31:0];
              pend_valid_d = !div_by_zero;
            end
            default: begin
              cnt_d        = CntW'(DIV_CYCLES);
              pend_hi_d    = rem_u;
              pend_lo_d    = quo_u;
              pend_valid_d = !div_by_zero;
            end
          endcase
        end else if (MDUOP == OpMthi) begin
          hi_d = SrcA;
        end else if (MDUOP == OpMtlo) begin
          lo_d = SrcA;
        end
      end
      StBusy: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StIdle;
          if (pend_valid_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs: Busy decoded from the state register, MF read mux
  always_comb begin
    Busy   = (state_q == StBusy);
    HI     = hi_q;
    LO     = lo_q;
    MDUOut = 32'd0;
    if (MDUOP == OpMfhi) begin
      MDUOut = hi_q;
    end else if (MDUOP == OpMflo) begin
      MDUOut = lo_q;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit with a cycle-level reference model.
module tb_mult_div_unit;

  localparam int unsigned MultN = 5;
  localparam int unsigned DivN  = 10;

  logic        clk;
  logic        reset;
  logic [3:0]  MDUOP;
  logic        Start;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDUOut;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model state
  bit          m_busy = 1'b0;
  int          m_rem  = 0;
  bit          m_pv   = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;

  mult_div_unit #(
    .MULT_CYCLES(MultN),
    .DIV_CYCLES (DivN)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .MDUOP (MDUOP),
    .Start (Start),
    .SrcA  (SrcA),
    .SrcB  (SrcB),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO),
    .MDUOut(MDUOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: an accepted op yields its 64-bit result from plain arithmetic and
  // becomes architecturally visible after a fixed number of busy cycles.
  always @(posedge clk) begin
    longint          sa, sb, q, r;
    longint unsigned ua, ub, p;
    logic [63:0]     res;
    bit              ok;
    if (reset) begin
      m_busy <= 1'b0; m_rem <= 0; m_pv <= 1'b0; m_hi <= '0; m_lo <= '0;
    end else if (m_busy) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) begin
        m_busy <= 1'b0;
        if (m_pv) begin
          m_hi <= m_phi;
          m_lo <= m_plo;
        end
      end
    end else if (Start && MDUOP >= 4'd1 && MDUOP <= 4'd4) begin
      sa = longint'($signed(SrcA));
      sb = longint'($signed(SrcB));
      ua = {32'd0, SrcA};
      ub = {32'd0, SrcB};
      ok = 1'b1;
      res = '0;
      case (MDUOP)
        4'd1: res = sa * sb;
        4'd2: begin p = ua * ub; res = p; end
        4'd3: if (SrcB == 0) ok = 1'b0;
              else begin q = sa / sb; r = sa % sb; res = {r[31:0], q[31:0]}; end
        default: if (SrcB == 0) ok = 1'b0;
                 else begin p = ua / ub; ub = ua % ub; res = {ub[31:0], p[31:0]}; end
      endcase
      m_phi  <= res[63:32];
      m_plo  <= res[31:0];
      m_pv   <= ok;
      m_busy <= 1'b1;
      m_rem  <= (MDUOP <= 4'd2) ? int'(MultN) : int'(DivN);
    end else if (MDUOP == 4'd7) begin
      m_hi <= SrcA;
    end else if (MDUOP == 4'd8) begin
      m_lo <= SrcA;
    end
  end

  // Compare DUT against model mid-cycle
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_busy", {31'd0, Busy}, {31'd0, m_busy});
      check("model_hi", HI, m_hi);
      check("model_lo", LO, m_lo);
      check("model_mduout", MDUOut, (MDUOP == 4'd5) ? m_hi : (MDUOP == 4'd6) ? m_lo : 32'd0);
    end
  end

  // Start an op, count its busy cycles (bounded) and check the count
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n);
    int cnt;
    MDUOP = op; Start = 1'b1; SrcA = a; SrcB = b;
    tick();
    MDUOP = 4'd0; Start = 1'b0;
    cnt = 0;
    while (Busy && cnt < 64) begin
      cnt++;
      tick();
    end
    check({name, "_busy_cycles"}, 32'(cnt), 32'(n));
  endtask

  initial begin
    int cnt;
    reset = 1'b1; MDUOP = 4'd0; Start = 1'b0; SrcA = '0; SrcB = '0;
    tick(); tick();
    check("reset_busy", {31'd0, Busy}, 32'd0);
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);
    reset = 1'b0;
    chk_en = 1'b1;

    // MULT with per-cycle busy window
    MDUOP = 4'd1; Start = 1'b1; SrcA = 32'hFFFF_FFFE; SrcB = 32'd3;
    tick();
    MDUOP = 4'd0; Start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("mult_busy_window", {31'd0, Busy}, 32'd1);
      tick();
    end
    check("mult_busy_drop", {31'd0, Busy}, 32'd0);
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFFA);

    run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
    check("multu_hi", HI, 32'hFFFF_FFFE);
    check("multu_lo", LO, 32'h0000_0001);

    run_op("div_neg", 4'd3, 32'hFFFF_FFF9, 32'd2, 10);
    check("div_neg_lo", LO, 32'hFFFF_FFFD);
    check("div_neg_hi", HI, 32'hFFFF_FFFF);

    run_op("divu", 4'd4, 32'd7, 32'd2, 10);
    check("divu_lo", LO, 32'd3);
    check("divu_hi", HI, 32'd1);

    run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10);
    check("div_ovf_lo", LO, 32'h8000_0000);
    check("div_ovf_hi", HI, 32'd0);

    // MTHI then MFHI / MFLO reads
    MDUOP = 4'd7; SrcA = 32'h1234;
    tick();
    MDUOP = 4'd5;
    #1 check("mfhi", MDUOut, 32'h1234);
    MDUOP = 4'd6;
    #1 check("mflo", MDUOut, 32'h8000_0000);
    MDUOP = 4'd0;
    tick();

    run_op("div_100_7", 4'd3, 32'd100, 32'd7, 10);
    check("div_100_7_lo", LO, 32'd14);
    check("div_100_7_hi", HI, 32'd2);

    // Divide by zero with an MTLO attempted while busy
    MDUOP = 4'd3; Start = 1'b1; SrcA = 32'd55; SrcB = 32'd0;
    tick();
    Start = 1'b0; MDUOP = 4'd8; SrcA = 32'hDEAD_BEEF;
    tick();
    MDUOP = 4'd0;
    cnt = 1;
    while (Busy && cnt < 64) begin
      cnt++;
      tick();
    end
    check("div0_busy_cycles", 32'(cnt), 32'd10);
    check("div0_lo_kept", LO, 32'd14);
    check("div0_hi_kept", HI, 32'd2);

    // Back-to-back: MULT issued in the single idle cycle after a DIVU
    MDUOP = 4'd4; Start = 1'b1; SrcA = 32'd50; SrcB = 32'd8;
    tick();
    MDUOP = 4'd0; Start = 1'b0;
    cnt = 0;
    while (Busy && cnt < 64) begin
      cnt++;
      tick();
    end
    check("b2b_div_cycles", 32'(cnt), 32'd10);
    check("b2b_div_lo", LO, 32'd6);
    check("b2b_div_hi", HI, 32'd2);
    run_op("b2b_mult", 4'd1, 32'd7, 32'hFFFF_FFFD, 5);
    check("b2b_mult_hi", HI, 32'hFFFF_FFFF);
    check("b2b_mult_lo", LO, 32'hFFFF_FFEB);

    // Start with non-arith ops must not raise Busy
    MDUOP = 4'd9; Start = 1'b1;
    tick();
    check("op9_no_busy", {31'd0, Busy}, 32'd0);
    MDUOP = 4'd5;
    tick();
    check("mfhi_start_no_busy", {31'd0, Busy}, 32'd0);
    MDUOP = 4'd0; Start = 1'b0;
    tick();

    // Reset in the middle of a DIV
    MDUOP = 4'd3; Start = 1'b1; SrcA = 32'd100; SrcB = 32'd7;
    tick();
    MDUOP = 4'd0; Start = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    check("abort_busy", {31'd0, Busy}, 32'd0);
    check("abort_hi", HI, 32'd0);
    check("abort_lo", LO, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    check("abort_no_commit_lo", LO, 32'd0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
